// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: iterative 32x32 unsigned multiplier that owns the HI/LO
// register pair.
// MULTU writes {hi,lo} = src_a * src_b 32 edges after start is sampled.
// MADDU writes {hi,lo} = {hi,lo} + src_a * src_b (mod 2^64) after 33 edges.
// Optional feature macro: HILO_MT_EN adds an MTHI/MTLO write port.
// In the default build that port is absent.
module hilo_mul_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mf_req,
    input  logic        mf_sel,
`ifdef HILO_MT_EN
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
`endif
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACC  = 2'd2
    } state_t;

    // Control state.
    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Datapath state. It carries no reset because it is only read while
    // RUN/ACC, and it is always reloaded on entry to RUN.
    logic        r_op;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_prod;

    logic [63:0] w_step_prod;
    logic [63:0] w_acc_sum;
    logic        w_last_step;
    logic        w_accept;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. The 64-bit partial product cannot overflow,
    // because the final value is at most (2^32-1)^2.
    assign w_step_prod = r_prod + (r_mplier[0] ? r_mcand : 64'd0);

    // MADDU accumulation wraps modulo 2^64. The carry out is dropped.
    assign w_acc_sum   = {r_hi, r_lo} + r_prod;

    // Counter value 31 marks the 32nd and final RUN step.
    assign w_last_step = (r_cnt == 6'd31);

    // A start is only taken in IDLE. A start seen while busy is ignored.
    assign w_accept    = (r_state == IDLE) && start;

    // Combinational read port. The done cycle already sees the new HI/LO.
    assign mf_data = mf_sel ? r_hi : r_lo;

    // Freeze the pipeline while a requester waits on the busy unit.
    // With MT writes enabled, an MT write is also held off in two cases:
    // - while busy;
    // - when it collides with a start. The start wins that collision.
`ifdef HILO_MT_EN
    assign stall = (r_busy && (start || mf_req || mt_we)) || (start && mt_we);
`else
    assign stall = r_busy && (start || mf_req);
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Control FSM: sequences RUN/ACC, and owns HI/LO, busy and done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b1;
                    end
`ifdef HILO_MT_EN
                    else if (mt_we) begin
                        if (mt_sel) begin
                            r_hi <= mt_data;
                        end else begin
                            r_lo <= mt_data;
                        end
                    end
`endif
                end
                RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last_step) begin
                        if (r_op) begin
                            r_state <= ACC;
                        end else begin
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            {r_hi, r_lo} <= w_step_prod;
                        end
                    end
                end
                ACC: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    {r_hi, r_lo} <= w_acc_sum;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shift-add datapath.
    // - An accepted start loads the operands.
    // - Each RUN cycle advances the operands by one bit.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= op;
            r_mcand  <= {32'd0, src_a};
            r_mplier <= src_b;
            r_prod   <= 64'd0;
        end else if (r_state == RUN) begin
            r_prod   <= w_step_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Self-checking bench for hilo_mul_ctrl.
// The bench runs a table of hand-computed vectors.
// It adds hand-written sequences for these cases:
// - reset behaviour;
// - a read request while busy;
// - the optional MT port (HILO_MT_EN).
// It ends with randomized ops checked against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_hilo_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mf_req;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef HILO_MT_EN
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;
`endif

    int n_checks;
    int n_fail;

    hilo_mul_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .mf_req  (mf_req),
        .mf_sel  (mf_sel),
`ifdef HILO_MT_EN
        .mt_we   (mt_we),
        .mt_sel  (mt_sel),
        .mt_data (mt_data),
`endif
        .mf_data (mf_data),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got no end, required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one op at the current negedge and follow it to its done cycle.
    // mf_at:  RUN cycle index at which mf_req is raised and then held (-1 = never).
    // ign_at: RUN cycle index with a one-cycle start pulse that must be ignored (-1 = never).
    // The task returns at the negedge of the done cycle, so the caller can
    // issue the next op right there.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input int mf_at, input int ign_at, input logic [63:0] exp_v);
        int lat;
        lat    = o ? 33 : 32;
        start  = 1'b1;
        op     = o;
        src_a  = a;
        src_b  = b;
        mf_sel = 1'b0;
        @(posedge clk);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy", 64'(busy), 64'(i < lat));
            check("done", 64'(done), 64'(i == lat));
            mf_req = (mf_at >= 0 && i >= mf_at) ? 1'b1 : 1'b0;
            if (i == ign_at) begin
                start = 1'b1;
                op    = ~o;
                src_a = $urandom;
                src_b = $urandom;
            end
            #1;
            check("stall", 64'(stall), 64'((i < lat) && (start || mf_req)));
        end
        check("hi", 64'(hi), 64'(exp_v[63:32]));
        check("lo", 64'(lo), 64'(exp_v[31:0]));
        check("mf_data_lo", 64'(mf_data), 64'(exp_v[31:0]));
        mf_sel = 1'b1;
        #1;
        check("mf_data_hi", 64'(mf_data), 64'(exp_v[63:32]));
        mf_sel = 1'b0;
        mf_req = 1'b0;
    endtask

    initial begin
        logic [63:0] model;
        logic [63:0] pa;
        logic [63:0] pb;
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          mfa;
        int          ign;
        int          gap;
        int          seen_done;

        n_checks = 0;
        n_fail   = 0;

        // MULTU and MADDU rows. Each row is issued in the previous row's done cycle.
        tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        tbl[1] = '{1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F};
        tbl[2] = '{1'b1, 32'h00000002, 32'h00000007, 64'h00000000_0000001D};
        tbl[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_00000000};
        tbl[5] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF};
        tbl[6] = '{1'b1, 32'h00000001, 32'h00000001, 64'h00000000_00000000};
        tbl[7] = '{1'b0, 32'h00000000, 32'h12345678, 64'h00000000_00000000};
        tbl[8] = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
        tbl[9] = '{1'b1, 32'h80000000, 32'h00000002, 64'h00000002_00000000};

        // Reset, asserted together with start and mf_req, which reset must override.
        rst    = 1'b0;
        start  = 1'b1;
        op     = 1'b1;
        src_a  = 32'h0000_0009;
        src_b  = 32'h0000_0009;
        mf_req = 1'b1;
        mf_sel = 1'b0;
`ifdef HILO_MT_EN
        mt_we   = 1'b1;
        mt_sel  = 1'b1;
        mt_data = 32'hA5A5A5A5;
`endif
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst    = 1'b1;
        start  = 1'b0;
        mf_req = 1'b0;
`ifdef HILO_MT_EN
        mt_we  = 1'b0;
`endif

        // Table vectors, issued back to back in each done cycle.
        for (int k = 0; k < 10; k++) begin
            run_op(tbl[k].op, tbl[k].a, tbl[k].b, -1, -1, tbl[k].exp);
        end
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);

        // Read request raised in RUN cycle 10. It stalls until the done cycle,
        // and the done cycle returns the new lo.
        pa = 64'hDEADBEEF;
        pb = 64'h00001234;
        run_op(1'b0, 32'hDEADBEEF, 32'h00001234, 10, -1, pa * pb);
        @(negedge clk);

`ifdef HILO_MT_EN
        // MT write in IDLE, then MT write during RUN, which must stall and be ignored.
        mt_we   = 1'b1;
        mt_sel  = 1'b1;
        mt_data = 32'h12345678;
        #1;
        check("mt_idle_stall", 64'(stall), 64'd0);
        @(negedge clk);
        mt_we = 1'b0;
        check("mt_hi", 64'(hi), 64'h12345678);
        start = 1'b1;
        op    = 1'b0;
        src_a = 32'd2;
        src_b = 32'd3;
        @(negedge clk);
        start   = 1'b0;
        mt_we   = 1'b1;
        mt_data = 32'hCAFEF00D;
        #1;
        check("mt_run_stall", 64'(stall), 64'd1);
        @(negedge clk);
        mt_we = 1'b0;
        check("mt_run_hi", 64'(hi), 64'h12345678);
        seen_done = 0;
        for (int j = 0; j < 40 && seen_done == 0; j++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("mt_done_seen", 64'(seen_done), 64'd1);
        check("mt_mul_hi", 64'(hi), 64'd0);
        check("mt_mul_lo", 64'(lo), 64'd6);
        // Preset all-ones through MT, then MADDU 1x1 wraps to zero.
        mt_we   = 1'b1;
        mt_sel  = 1'b0;
        mt_data = 32'hFFFFFFFF;
        @(negedge clk);
        mt_sel  = 1'b1;
        @(negedge clk);
        mt_we   = 1'b0;
        check("mt_preset", {32'd0, hi} & {32'd0, lo}, 64'hFFFFFFFF);
        run_op(1'b1, 32'd1, 32'd1, -1, -1, 64'd0);
        @(negedge clk);
`endif

        // Randomized ops against the arithmetic model. The first op is a
        // MULTU, so the model starts from a known value.
        model = 64'd0;
        for (int k = 0; k < 24; k++) begin
            ro = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            pa    = {32'd0, ra};
            pb    = {32'd0, rb};
            model = ro ? (model + pa * pb) : (pa * pb);
            mfa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1;
            ign   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1;
            run_op(ro, ra, rb, mfa, ign, model);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_done", 64'(done), 64'd0);
            end
        end
        @(negedge clk);

        // Reset in RUN cycle 20 discards the op: HI/LO clear and no done pulse follows.
        start = 1'b1;
        op    = 1'b1;
        src_a = 32'hFFFFFFFF;
        src_b = 32'h7FFFFFFF;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst    = 1'b0;
        mf_req = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        rst    = 1'b1;
        mf_req = 1'b0;
        seen_done = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("mid_rst_no_done", 64'(seen_done), 64'd0);
        run_op(1'b0, 32'd6, 32'd7, -1, -1, 64'd42);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
